// File: rtl/mux_nway_skid.sv
// N-way operand select feeding a 2-entry skid buffer.
// The selected operand is registered into an output slot (O) and, under
// back-pressure, into a skid slot (S). Transfers use valid/ready handshakes
// on both sides, and out-of-range selects raise a sticky error flag.
module mux_nway_skid #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        r,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    sel_err,
  output logic [1:0]              count
);

  // Occupancy encoding: bit 0 is O.valid and bit 1 is S.valid. S is only
  // ever occupied while O is, so the valid/ready outputs are plain register
  // bits with no decode.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_o_data;
  logic [WIDTH-1:0]   r_s_data;
  logic               r_sel_err;
  logic [WIDTH-1:0]   w_mux;
  logic [31:0]        w_sel_ext;
  logic               w_sel_ok;
  logic               w_accept;
  logic               w_consume;
  logic               w_ld_o_in;
  logic               w_ld_o_s;
  logic               w_ld_s;

  assign w_sel_ext = 32'(sel);
  assign w_sel_ok  = (w_sel_ext < 32'(NUM_IN));

  assign r_valid   = r_state[0];
  assign in_ready  = ~r_state[1];
  assign count     = {r_state[1], r_state[0] & ~r_state[1]};
  assign r         = r_o_data;
  assign sel_err   = r_sel_err;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_valid & r_ready;

  // Operand select. Channel 0 is the fallback, so an out-of-range select
  // returns channel 0 and unselected channels never reach the result.
  always_comb begin
    w_mux = in_bus[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      if (w_sel_ext == k) begin
        w_mux = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and slot load strobes; O always holds the older word.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_o_in   = 1'b0;
    w_ld_o_s    = 1'b0;
    w_ld_s      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_ld_o_in   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_consume && w_accept) begin
          w_ld_o_in = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_ld_s      = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_consume) begin
          w_state_nxt = ST_ONE;
          w_ld_o_s    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Slot data registers; r only changes when O is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_data <= '0;
      r_s_data <= '0;
    end else begin
      if (w_ld_o_in) begin
        r_o_data <= w_mux;
      end else if (w_ld_o_s) begin
        r_o_data <= r_s_data;
      end
      if (w_ld_s) begin
        r_s_data <= w_mux;
      end
    end
  end

  // Sticky out-of-range select flag, set only by an accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end
  end

endmodule
